// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared types and constants for the FP16 mul/div controller.
//               Holds the FSM state enum, the operation enum, the FP16
//               field widths and the iteration count of the core.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  localparam int NUM_BITS   = 16;
  localparam int EXP_WIDTH  = 5;
  localparam int MANT_WIDTH = 10;
  localparam int BIAS       = 15;
  localparam int FLAG_W     = 6;  // {zero, inf, subN, Norm, QNan, SNan}

  // Hidden bit + guard bit on top of the stored mantissa.
  localparam int ITER_COUNT = MANT_WIDTH + 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_ITER = 3'd2,
    ST_POST = 3'd3,
    ST_RESP = 3'd4
  } state_e;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_e;

endpackage
`default_nettype wire

// File: rtl/muldiv_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_ctrl_if
// Description : Request/response bundle between two requesters and the
//               mul/div controller.
// Ports       : req_valid/req_ready/req_op/req_a/req_b - one lane per
//               requester (index 0 and 1)
//               resp_valid/resp_ready/resp_id/resp_result/resp_flags/
//               resp_special - single shared response channel
//               master modport: requester side, slave modport: controller
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_ctrl_if
  import muldiv_pkg::*;
#(
  parameter int num_bits = NUM_BITS
) ();

  logic [1:0]                req_valid;
  logic [1:0]                req_ready;
  logic [1:0]                req_op;
  logic [1:0][num_bits-1:0]  req_a;
  logic [1:0][num_bits-1:0]  req_b;

  logic                      resp_valid;
  logic                      resp_ready;
  logic                      resp_id;
  logic [num_bits-1:0]       resp_result;
  logic [FLAG_W-1:0]         resp_flags;
  logic                      resp_special;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_result, resp_flags, resp_special
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_result, resp_flags, resp_special
  );

endinterface
`default_nettype wire

// File: rtl/muldiv_ctrl_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter. A lone requester always wins;
//               when both request, the pointer decides. The pointer moves to
//               the loser only when a transfer actually happens.
// Ports       : clk, rst_n (sync, active-low)
//               req_i[1:0]  - request lines
//               xfer_i      - granted request was accepted this cycle
//               gnt_o       - index of the granted requester
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       xfer_i,
  output logic       gnt_o
);

  logic ptr_q;
  logic ptr_d;

  // With no request at all the pointer's requester is offered the slot,
  // so requester 0 sees ready right after reset.
  always_comb begin
    gnt_o = ptr_q;
    if (req_i == 2'b01) begin
      gnt_o = 1'b0;
    end else if (req_i == 2'b10) begin
      gnt_o = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer_i) begin
      ptr_d = ~gnt_o;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_ctrl
// Description : Sequencing controller for an iterative FP16 mul/div core.
//               Arbitrates two requesters, registers the operands, lets the
//               datapath short-circuit special cases, steps the core for
//               ITER_COUNT cycles, rounds, and holds the response until it
//               is taken.
// Ports       : clk, rst_n        - clock, synchronous active-low reset
//               bus (slave)       - request lanes and response channel
//               dp_a/dp_b/dp_op   - registered operands to the datapath
//               dp_arithmetic     - 0: result comes from dp_direct_result
//               dp_direct_result  - special-case result
//               dp_flags          - operand classification flags
//               core_step/first/last/round - core sequencing strobes
//               core_result       - rounded core result (valid in POST)
//               busy              - controller not idle
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int num_bits   = NUM_BITS,
  parameter int exp_width  = EXP_WIDTH,
  parameter int mant_width = MANT_WIDTH,
  parameter int bias       = BIAS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  muldiv_ctrl_if.slave         bus,
  output logic [num_bits-1:0]  dp_a,
  output logic [num_bits-1:0]  dp_b,
  output logic                 dp_op,
  input  logic                 dp_arithmetic,
  input  logic [num_bits-1:0]  dp_direct_result,
  input  logic [FLAG_W-1:0]    dp_flags,
  output logic                 core_step,
  output logic                 core_first,
  output logic                 core_last,
  output logic                 core_round,
  input  logic [num_bits-1:0]  core_result,
  output logic                 busy
);

  localparam int ITER_N = mant_width + 2;
  localparam int CNT_W  = $clog2(ITER_N + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ITER_N);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] S_IDLE = ST_IDLE;
  localparam logic [2:0] S_PRE  = ST_PRE;
  localparam logic [2:0] S_ITER = ST_ITER;
  localparam logic [2:0] S_POST = ST_POST;
  localparam logic [2:0] S_RESP = ST_RESP;

  generate
    if (exp_width + mant_width + 1 != num_bits) begin : g_chk_width
      $error("muldiv_ctrl: sign + exponent + mantissa must equal num_bits");
    end
    if (bias != (1 << (exp_width - 1)) - 1) begin : g_chk_bias
      $error("muldiv_ctrl: bias must be 2**(exp_width-1)-1");
    end
  endgenerate

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [num_bits-1:0]  dp_a_q, dp_b_q;
  logic                 dp_op_q;
  logic                 id_q;
  logic [num_bits-1:0]  resp_result_q;
  logic [FLAG_W-1:0]    resp_flags_q;
  logic                 resp_special_q;

  logic                 gnt;
  logic                 xfer;

  assign xfer = (state_q == S_IDLE) && bus.req_valid[gnt];

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (bus.req_valid),
    .xfer_i (xfer),
    .gnt_o  (gnt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          state_d = S_PRE;
        end
      end
      S_PRE: begin
        cnt_d   = CNT_LOAD;
        state_d = dp_arithmetic ? S_ITER : S_RESP;
      end
      S_ITER: begin
        // Saturating decrement; the exit test on <= 1 keeps the FSM from
        // sticking in ITER even if the counter were ever corrupted to 0.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end
        if (cnt_q <= CNT_ONE) begin
          state_d = S_POST;
        end
      end
      S_POST: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      dp_a_q         <= '0;
      dp_b_q         <= '0;
      dp_op_q        <= 1'b0;
      id_q           <= 1'b0;
      resp_result_q  <= '0;
      resp_flags_q   <= '0;
      resp_special_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (xfer) begin
        dp_a_q  <= bus.req_a[gnt];
        dp_b_q  <= bus.req_b[gnt];
        dp_op_q <= bus.req_op[gnt];
        id_q    <= gnt;
      end
      if (state_q == S_PRE) begin
        resp_flags_q <= dp_flags;
        if (!dp_arithmetic) begin
          resp_result_q  <= dp_direct_result;
          resp_special_q <= 1'b1;
        end
      end
      if (state_q == S_POST) begin
        resp_result_q  <= core_result;
        resp_special_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready    = (state_q != S_IDLE) ? 2'b00 : (gnt ? 2'b10 : 2'b01);
  assign bus.resp_valid   = (state_q == S_RESP);
  assign bus.resp_id      = id_q;
  assign bus.resp_result  = resp_result_q;
  assign bus.resp_flags   = resp_flags_q;
  assign bus.resp_special = resp_special_q;

  assign dp_a  = dp_a_q;
  assign dp_b  = dp_b_q;
  assign dp_op = dp_op_q;

  assign core_step  = (state_q == S_ITER);
  assign core_first = (state_q == S_ITER) && (cnt_q == CNT_LOAD);
  assign core_last  = (state_q == S_ITER) && (cnt_q == CNT_ONE);
  assign core_round = (state_q == S_POST);

  assign busy = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_ctrl
// Description : Scoreboard bench for muldiv_ctrl. Stimulus pushes the
//               expected response before issuing a request; a monitor checks
//               latency, strobes, operands and response fields on every
//               response handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_ctrl_if bus ();

  logic [15:0] dp_a, dp_b, dp_direct_result, core_result;
  logic        dp_op, dp_arithmetic;
  logic [5:0]  dp_flags;
  logic        core_step, core_first, core_last, core_round, busy;

  // Datapath stub driven from bench variables.
  logic        arith_v   = 1'b0;
  logic [15:0] dir_v     = 16'h0;
  logic [15:0] core_v    = 16'h0;
  logic [5:0]  flags_v   = 6'h0;
  logic        dir_from_a = 1'b0;

  assign dp_arithmetic    = arith_v;
  assign dp_flags         = flags_v;
  assign dp_direct_result = dir_from_a ? dp_a : dir_v;
  assign core_result      = core_v;

  muldiv_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus),
    .dp_a             (dp_a),
    .dp_b             (dp_b),
    .dp_op            (dp_op),
    .dp_arithmetic    (dp_arithmetic),
    .dp_direct_result (dp_direct_result),
    .dp_flags         (dp_flags),
    .core_step        (core_step),
    .core_first       (core_first),
    .core_last        (core_last),
    .core_round       (core_round),
    .core_result      (core_result),
    .busy             (busy)
  );

  typedef struct {
    logic        id;
    logic [15:0] a;
    logic [15:0] b;
    logic        op;
    logic [15:0] res;
    logic [5:0]  flags;
    logic        special;
    int          lat;
    int          steps;
  } exp_t;

  exp_t exp_q[$];
  int   xq[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout/none required=event", name);
  endtask

  task automatic push_exp(input logic id, input logic [15:0] a, input logic [15:0] b,
                          input logic op, input logic [15:0] res, input logic [5:0] fl,
                          input logic sp);
    exp_t e;
    e.id = id; e.a = a; e.b = b; e.op = op; e.res = res; e.flags = fl; e.special = sp;
    e.lat   = sp ? 2 : 15;
    e.steps = sp ? 0 : 12;
    exp_q.push_back(e);
  endtask

  // Inputs change 1 time unit after the rising edge; monitor samples on the
  // falling edge.
  task automatic issue(input int r, input logic op, input logic [15:0] a, input logic [15:0] b);
    bit got = 0;
    @(posedge clk); #1;
    bus.req_valid[r] = 1'b1;
    bus.req_op[r]    = op;
    bus.req_a[r]     = a;
    bus.req_b[r]     = b;
    for (int k = 0; k < 200 && !got; k++) begin
      #1;
      if (bus.req_ready[r]) got = 1;
      else begin @(posedge clk); #1; end
    end
    if (!got) fail("req_accept_timeout");
    @(posedge clk); #1;
    bus.req_valid[r] = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (exp_q.size() != 0 || busy) fail("drain_timeout");
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"},      32'(busy), 32'(0));
    chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'(0));
    chk({tag, "_resp_result"}, 32'(bus.resp_result), 32'(0));
    chk({tag, "_resp_flags"}, 32'(bus.resp_flags), 32'(0));
    chk({tag, "_resp_id"},    32'(bus.resp_id), 32'(0));
    chk({tag, "_resp_special"}, 32'(bus.resp_special), 32'(0));
    chk({tag, "_dp_ab"},      {dp_a, dp_b}, 32'(0));
    chk({tag, "_dp_op"},      32'(dp_op), 32'(0));
    chk({tag, "_core"},       32'({core_step, core_first, core_last, core_round}), 32'(0));
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t        e;
    logic        cont = 1'b0;
    logic        after_hs = 1'b0;
    logic [15:0] p_res;
    logic [5:0]  p_fl;
    logic        p_id, p_sp;
    int          step_cnt = 0, first_pos = 0, last_pos = 0, round_cnt = 0, t0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        step_cnt = 0; first_pos = 0; last_pos = 0; round_cnt = 0;
        xq.delete();
        cont = 1'b0; after_hs = 1'b0;
      end else begin
        if (after_hs) begin
          chk("idle_after_resp", 32'(busy), 32'(0));
          after_hs = 1'b0;
        end
        if (core_step) begin
          step_cnt++;
          if (core_first) first_pos = step_cnt;
          if (core_last)  last_pos  = step_cnt;
        end
        if (core_round) round_cnt++;
        if ((bus.req_valid & bus.req_ready) != 2'b00) xq.push_back(cyc);
        if (bus.resp_valid) begin
          chk("req_ready_in_resp", 32'(bus.req_ready), 32'(0));
          if (!cont) begin
            if (exp_q.size() == 0) fail("unexpected_resp");
            else if (xq.size() == 0) fail("resp_without_xfer");
            else begin
              t0 = xq.pop_front();
              chk("latency", 32'(cyc - t0), 32'(exp_q[0].lat));
            end
          end else begin
            chk("stable_result",  32'(bus.resp_result), 32'(p_res));
            chk("stable_flags",   32'(bus.resp_flags), 32'(p_fl));
            chk("stable_id_spec", 32'({bus.resp_id, bus.resp_special}), 32'({p_id, p_sp}));
          end
          if (bus.resp_ready && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("resp_result",  32'(bus.resp_result), 32'(e.res));
            chk("resp_flags",   32'(bus.resp_flags), 32'(e.flags));
            chk("resp_id",      32'(bus.resp_id), 32'(e.id));
            chk("resp_special", 32'(bus.resp_special), 32'(e.special));
            chk("dp_a",         32'(dp_a), 32'(e.a));
            chk("dp_b",         32'(dp_b), 32'(e.b));
            chk("dp_op",        32'(dp_op), 32'(e.op));
            chk("step_count",   32'(step_cnt), 32'(e.steps));
            chk("round_count",  32'(round_cnt), 32'(e.steps != 0));
            chk("first_pos",    32'(first_pos), 32'(e.steps != 0));
            chk("last_pos",     32'(last_pos), 32'(e.steps));
            step_cnt = 0; first_pos = 0; last_pos = 0; round_cnt = 0;
            after_hs = 1'b1;
          end
        end
        cont  = bus.resp_valid && !bus.resp_ready;
        p_res = bus.resp_result;
        p_fl  = bus.resp_flags;
        p_id  = bus.resp_id;
        p_sp  = bus.resp_special;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bit seen;
    bus.req_valid  = 2'b00;
    bus.req_op     = 2'b00;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outs("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(bus.req_ready), 32'(2'b01));

    // 1.0 * 2.0 through the core
    @(posedge clk); #1;
    arith_v = 1'b1; core_v = 16'h4000; flags_v = 6'b000100; dir_from_a = 1'b0;
    push_exp(1'b0, 16'h3C00, 16'h4000, OP_MUL, 16'h4000, 6'b000100, 1'b0);
    issue(0, OP_MUL, 16'h3C00, 16'h4000);
    drain();

    // inf / inf -> QNaN via the direct path
    arith_v = 1'b0; dir_v = 16'h7E00; flags_v = 6'b000010;
    push_exp(1'b1, 16'h7C00, 16'h7C00, OP_DIV, 16'h7E00, 6'b000010, 1'b1);
    issue(1, OP_DIV, 16'h7C00, 16'h7C00);
    drain();

    // 4.0 / 2.0 through the core from requester 1
    arith_v = 1'b1; core_v = 16'h4000; flags_v = 6'b000100;
    push_exp(1'b1, 16'h4400, 16'h4000, OP_DIV, 16'h4000, 6'b000100, 1'b0);
    issue(1, OP_DIV, 16'h4400, 16'h4000);
    drain();

    // 0 * 1.0 -> zero via the direct path
    arith_v = 1'b0; dir_v = 16'h0000; flags_v = 6'b100000;
    push_exp(1'b0, 16'h0000, 16'h3C00, OP_MUL, 16'h0000, 6'b100000, 1'b1);
    issue(0, OP_MUL, 16'h0000, 16'h3C00);
    drain();

    // Back-pressure on the response channel
    bus.resp_ready = 1'b0;
    arith_v = 1'b0; dir_v = 16'h7C00; flags_v = 6'b010000;
    push_exp(1'b0, 16'h7BFF, 16'h0400, OP_MUL, 16'h7C00, 6'b010000, 1'b1);
    issue(0, OP_MUL, 16'h7BFF, 16'h0400);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (bus.resp_valid) seen = 1;
    end
    if (!seen) fail("stall_resp_timeout");
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(bus.resp_valid), 32'(1));
      chk("stall_busy",  32'(busy), 32'(1));
      @(negedge clk);
    end
    @(posedge clk); #1 bus.resp_ready = 1'b1;
    drain();

    // Round-robin with both requesters asserting continuously after reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    arith_v = 1'b0; dir_from_a = 1'b1; flags_v = 6'b001000;
    push_exp(1'b0, 16'h1111, 16'h0001, OP_MUL, 16'h1111, 6'b001000, 1'b1);
    push_exp(1'b1, 16'h2222, 16'h0002, OP_DIV, 16'h2222, 6'b001000, 1'b1);
    push_exp(1'b0, 16'h1111, 16'h0001, OP_MUL, 16'h1111, 6'b001000, 1'b1);
    push_exp(1'b1, 16'h2222, 16'h0002, OP_DIV, 16'h2222, 6'b001000, 1'b1);
    @(posedge clk); #1;
    bus.req_op = 2'b10;
    bus.req_a[0] = 16'h1111; bus.req_b[0] = 16'h0001;
    bus.req_a[1] = 16'h2222; bus.req_b[1] = 16'h0002;
    bus.req_valid = 2'b11;
    n = 0;
    for (int k = 0; k < 200 && n < 4; k++) begin
      @(negedge clk);
      if ((bus.req_valid & bus.req_ready) != 2'b00) n++;
    end
    @(posedge clk); #1 bus.req_valid = 2'b00;
    chk("rr_transfers", 32'(n), 32'(4));
    drain();
    dir_from_a = 1'b0;

    // Reset in the sixth ITER cycle abandons the operation
    arith_v = 1'b1; core_v = 16'h4880; flags_v = 6'b000100;
    issue(0, OP_MUL, 16'h4200, 16'h4200);
    n = 0;
    for (int k = 0; k < 50 && n < 6; k++) begin
      @(posedge clk); #1;
      if (core_step) n++;
    end
    if (n != 6) fail("iter_reach_timeout");
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outs("midop_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_midop", 32'(bus.req_ready), 32'(2'b01));

    // Normal operation afterwards: 1.0 * 1.5
    @(posedge clk); #1;
    core_v = 16'h3E00;
    push_exp(1'b0, 16'h3C00, 16'h3E00, OP_MUL, 16'h3E00, 6'b000100, 1'b0);
    issue(0, OP_MUL, 16'h3C00, 16'h3E00);
    drain();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
